// File: rtl/mac_accum_s8.sv
// mac_accum_s8: frame accumulator for the signed 4x4 multiplier's 8-bit products.
// Sums one frame of products into a signed ACC_W-bit accumulator. The frame
// closes on in_last or after MAX_TERMS beats. The result is presented with a
// valid/ready handshake, together with a sticky overflow flag and a term count.
// Build option: define MAC_ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
module mac_accum_s8 #(
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned MAX_TERMS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [7:0]       out_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_next;
  logic [7:0]       cnt_next;
  logic             add_ovf;
  logic             accept;
  logic             close;

  // Next accumulator value, signed overflow detection and frame-close condition
  always_comb begin
    prod_ext = {{(ACC_W-8){in_prod[7]}}, in_prod};
    sum      = acc + prod_ext;
    add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef MAC_ACCUM_SATURATE_EN
    if (add_ovf)
      acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_next = sum;
`else
    acc_next = sum;
`endif
    cnt_next = cnt + 8'd1;
    close    = in_last || (cnt_next == 8'(MAX_TERMS));
    accept   = in_valid && in_ready;
  end

  // Frame FSM; in_ready and all out_* are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (clear) begin
      // out_acc/out_ovf/out_cnt keep their last values; out_valid=0 qualifies them
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf | add_ovf;
            if (close) begin
              out_acc   <= acc_next;
              out_ovf   <= ovf | add_ovf;
              out_cnt   <= cnt_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
